// File: rtl/fifo_async_stat.sv
// Dual-clock FIFO with gray-coded pointer crossing, per-domain fill counts,
// optional registered first-word-fall-through output and sticky error flags.
module fifo_async_stat #(
    parameter int    DATA_WIDTH       = 8,
    parameter int    DEPTH            = 16,
    parameter int    N_FLOP_CROSS     = 2,
    parameter int    ALMOST_WR_MARGIN = 2,
    parameter int    ALMOST_RD_MARGIN = 2,
    parameter int    FWFT             = 0,
    parameter string INSTANCE_NAME    = "FIFO_STAT"
) (
    input  logic                      i_wr_clk,
    input  logic                      i_wr_rst_n,
    input  logic                      i_rd_clk,
    input  logic                      i_rd_rst_n,
    input  logic                      i_write,
    input  logic [DATA_WIDTH-1:0]     i_wr_data,
    input  logic                      i_wr_clr_err,
    output logic                      o_wr_full,
    output logic                      o_wr_almost_full,
    output logic [$clog2(DEPTH):0]    o_wr_count,
    output logic                      o_wr_overflow,
    input  logic                      i_read,
    input  logic                      i_rd_clr_err,
    output logic [DATA_WIDTH-1:0]     o_rd_data,
    output logic                      o_rd_empty,
    output logic                      o_rd_almost_empty,
    output logic [$clog2(DEPTH):0]    o_rd_count,
    output logic                      o_rd_underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fifo_async_stat: DEPTH must be a power of two and at least 4");
    end
    if (N_FLOP_CROSS < 2) begin : g_bad_sync
        $error("fifo_async_stat: N_FLOP_CROSS must be at least 2");
    end
    if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
        $error("fifo_async_stat: FWFT must be 0 or 1");
    end

    function automatic logic [CW-1:0] bin2gray(input logic [CW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [CW-1:0] gray2bin(input logic [CW-1:0] g);
        logic [CW-1:0] b;
        b[CW-1] = g[CW-1];
        for (int i = CW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // ---------------------------------------------------------------- write domain
    logic [CW-1:0] wr_bin_q, wr_bin_d, wr_gray_q;
    logic [CW-1:0] wsync_q [N_FLOP_CROSS];
    logic [CW-1:0] wdom_rd_bin, wr_cnt_d, wr_cnt_q;
    logic          wr_en;
    logic          wr_full_q, wr_full_d;
    logic          wr_afull_q, wr_afull_d;
    logic          wr_ovf_q, wr_ovf_d;
    logic [CW-1:0] rd_gray_q;

    // NOTE: every signal is assigned on every path through this block, so no latch is inferred.
    always_comb begin
        wr_en       = i_write & ~wr_full_q;
        wr_bin_d    = wr_bin_q + CW'(wr_en);
        wdom_rd_bin = gray2bin(wsync_q[N_FLOP_CROSS-1]);
        wr_cnt_d    = wr_bin_d - wdom_rd_bin;
        wr_full_d   = (wr_cnt_d == CW'(DEPTH));
        wr_afull_d  = (int'(wr_cnt_d) >= DEPTH - ALMOST_WR_MARGIN);
        wr_ovf_d    = (i_write & wr_full_q) | (wr_ovf_q & ~i_wr_clr_err);
    end

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values regardless of block order.
    always_ff @(posedge i_wr_clk or negedge i_wr_rst_n) begin
        if (!i_wr_rst_n) begin
            wr_bin_q   <= '0;
            wr_gray_q  <= '0;
            wr_cnt_q   <= '0;
            wr_full_q  <= 1'b0;
            wr_afull_q <= (ALMOST_WR_MARGIN >= DEPTH);
            wr_ovf_q   <= 1'b0;
            for (int i = 0; i < N_FLOP_CROSS; i++) begin
                wsync_q[i] <= '0;
            end
        end else begin
            wr_bin_q   <= wr_bin_d;
            wr_gray_q  <= bin2gray(wr_bin_d);
            wr_cnt_q   <= wr_cnt_d;
            wr_full_q  <= wr_full_d;
            wr_afull_q <= wr_afull_d;
            wr_ovf_q   <= wr_ovf_d;
            wsync_q[0] <= rd_gray_q;
            for (int i = 1; i < N_FLOP_CROSS; i++) begin
                wsync_q[i] <= wsync_q[i-1];
            end
        end
    end

    // NOTE: storage has no reset; stale words are never visible because the pointers gate every read.
    always_ff @(posedge i_wr_clk) begin
        if (wr_en) begin
            mem_q[wr_bin_q[AW-1:0]] <= i_wr_data;
        end
    end

    assign o_wr_full        = wr_full_q;
    assign o_wr_almost_full = wr_afull_q;
    assign o_wr_count       = wr_cnt_q;
    assign o_wr_overflow    = wr_ovf_q;

    // ----------------------------------------------------------------- read domain
    logic [CW-1:0]         rd_bin_q, rd_bin_d;
    logic [CW-1:0]         rsync_q [N_FLOP_CROSS];
    logic [CW-1:0]         rdom_wr_bin, mem_cnt_d, rd_cnt_d, rd_cnt_q;
    logic                  mem_nempty_q, mem_nempty_d;
    logic                  rd_adv, rd_illegal;
    logic                  rd_empty_q, rd_empty_d;
    logic                  rd_aempty_q, rd_aempty_d;
    logic                  rd_unf_q, rd_unf_d;
    logic [DATA_WIDTH-1:0] head_data;

    always_comb begin
        head_data    = mem_q[rd_bin_q[AW-1:0]];
        rdom_wr_bin  = gray2bin(rsync_q[N_FLOP_CROSS-1]);
        rd_bin_d     = rd_bin_q + CW'(rd_adv);
        mem_cnt_d    = rdom_wr_bin - rd_bin_d;
        mem_nempty_d = (mem_cnt_d != '0);
        rd_aempty_d  = (int'(rd_cnt_d) <= ALMOST_RD_MARGIN);
        rd_unf_d     = rd_illegal | (rd_unf_q & ~i_rd_clr_err);
    end

    if (FWFT != 0) begin : g_fwft
        logic                  out_valid_q, out_valid_d;
        logic [DATA_WIDTH-1:0] out_data_q;

        // The output register refills from memory whenever it is vacant or being popped.
        always_comb begin
            rd_adv      = mem_nempty_q & (~out_valid_q | i_read);
            out_valid_d = rd_adv | (out_valid_q & ~i_read);
            rd_illegal  = i_read & ~out_valid_q;
            rd_cnt_d    = mem_cnt_d + CW'(out_valid_d);
            rd_empty_d  = ~out_valid_d;
        end

        always_ff @(posedge i_rd_clk or negedge i_rd_rst_n) begin
            if (!i_rd_rst_n) begin
                out_valid_q <= 1'b0;
                out_data_q  <= '0;
            end else begin
                out_valid_q <= out_valid_d;
                if (rd_adv) begin
                    out_data_q <= head_data;
                end
            end
        end

        assign o_rd_data = out_data_q;
    end else begin : g_direct
        always_comb begin
            rd_adv     = i_read & mem_nempty_q;
            rd_illegal = i_read & ~mem_nempty_q;
            rd_cnt_d   = mem_cnt_d;
            rd_empty_d = ~mem_nempty_d;
        end

        assign o_rd_data = head_data;
    end

    always_ff @(posedge i_rd_clk or negedge i_rd_rst_n) begin
        if (!i_rd_rst_n) begin
            rd_bin_q     <= '0;
            rd_gray_q    <= '0;
            rd_cnt_q     <= '0;
            mem_nempty_q <= 1'b0;
            rd_empty_q   <= 1'b1;
            rd_aempty_q  <= 1'b1;
            rd_unf_q     <= 1'b0;
            for (int i = 0; i < N_FLOP_CROSS; i++) begin
                rsync_q[i] <= '0;
            end
        end else begin
            rd_bin_q     <= rd_bin_d;
            rd_gray_q    <= bin2gray(rd_bin_d);
            rd_cnt_q     <= rd_cnt_d;
            mem_nempty_q <= mem_nempty_d;
            rd_empty_q   <= rd_empty_d;
            rd_aempty_q  <= rd_aempty_d;
            rd_unf_q     <= rd_unf_d;
            rsync_q[0]   <= wr_gray_q;
            for (int i = 1; i < N_FLOP_CROSS; i++) begin
                rsync_q[i] <= rsync_q[i-1];
            end
        end
    end

    assign o_rd_empty        = rd_empty_q;
    assign o_rd_almost_empty = rd_aempty_q;
    assign o_rd_count        = rd_cnt_q;
    assign o_rd_underflow    = rd_unf_q;

    // ------------------------------------------------ one-sided reset detection
    // Each domain flags the other domain's reset falling while it is itself running.
    logic rd_rst_seen_q, wr_rst_seen_q;

    always_ff @(posedge i_wr_clk or negedge i_wr_rst_n) begin
        if (!i_wr_rst_n) begin
            rd_rst_seen_q <= 1'b0;
        end else begin
            rd_rst_seen_q <= i_rd_rst_n;
            assert (!(rd_rst_seen_q && !i_rd_rst_n))
            else $error("%s: read-domain reset without write-domain reset", INSTANCE_NAME);
        end
    end

    always_ff @(posedge i_rd_clk or negedge i_rd_rst_n) begin
        if (!i_rd_rst_n) begin
            wr_rst_seen_q <= 1'b0;
        end else begin
            wr_rst_seen_q <= i_wr_rst_n;
            assert (!(wr_rst_seen_q && !i_wr_rst_n))
            else $error("%s: write-domain reset without read-domain reset", INSTANCE_NAME);
        end
    end

endmodule

// File: tb/tb_fifo_async_stat.sv
// Bench for fifo_async_stat: a direct-read instance and an FWFT instance share
// the write side; a queue scoreboard checks ordering, flags, counts and errors.
`timescale 1ns/100ps
module tb_fifo_async_stat;

    localparam int DEPTH = 8;
    localparam int CW    = 4;
    localparam int N_RND = 10000;

    logic       i_wr_clk = 1'b0, i_rd_clk = 1'b0;
    logic       i_wr_rst_n = 1'b0, i_rd_rst_n = 1'b0;
    logic       i_write = 1'b0, i_wr_clr_err = 1'b0;
    logic [7:0] i_wr_data = 8'h00;
    logic       i_read = 1'b0, i_read_f = 1'b0, i_rd_clr_err = 1'b0;

    logic          wr_full, wr_afull, wr_ovf, rd_empty, rd_aempty, rd_unf;
    logic [CW-1:0] wr_count, rd_count;
    logic [7:0]    rd_data;
    logic          f_wr_full, f_wr_afull, f_wr_ovf, f_rd_empty, f_rd_aempty, f_rd_unf;
    logic [CW-1:0] f_wr_count, f_rd_count;
    logic [7:0]    f_rd_data;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_f_q[$];

    always #5    i_wr_clk = ~i_wr_clk;
    always #13.5 i_rd_clk = ~i_rd_clk;

    fifo_async_stat #(
        .DATA_WIDTH(8), .DEPTH(DEPTH), .N_FLOP_CROSS(2),
        .ALMOST_WR_MARGIN(2), .ALMOST_RD_MARGIN(2), .FWFT(0), .INSTANCE_NAME("DIRECT")
    ) u_dut (
        .i_wr_clk(i_wr_clk), .i_wr_rst_n(i_wr_rst_n), .i_rd_clk(i_rd_clk), .i_rd_rst_n(i_rd_rst_n),
        .i_write(i_write), .i_wr_data(i_wr_data), .i_wr_clr_err(i_wr_clr_err),
        .o_wr_full(wr_full), .o_wr_almost_full(wr_afull), .o_wr_count(wr_count), .o_wr_overflow(wr_ovf),
        .i_read(i_read), .i_rd_clr_err(i_rd_clr_err), .o_rd_data(rd_data), .o_rd_empty(rd_empty),
        .o_rd_almost_empty(rd_aempty), .o_rd_count(rd_count), .o_rd_underflow(rd_unf)
    );

    fifo_async_stat #(
        .DATA_WIDTH(8), .DEPTH(DEPTH), .N_FLOP_CROSS(2),
        .ALMOST_WR_MARGIN(2), .ALMOST_RD_MARGIN(2), .FWFT(1), .INSTANCE_NAME("PREFETCH")
    ) u_dut_fwft (
        .i_wr_clk(i_wr_clk), .i_wr_rst_n(i_wr_rst_n), .i_rd_clk(i_rd_clk), .i_rd_rst_n(i_rd_rst_n),
        .i_write(i_write), .i_wr_data(i_wr_data), .i_wr_clr_err(i_wr_clr_err),
        .o_wr_full(f_wr_full), .o_wr_almost_full(f_wr_afull), .o_wr_count(f_wr_count), .o_wr_overflow(f_wr_ovf),
        .i_read(i_read_f), .i_rd_clr_err(i_rd_clr_err), .o_rd_data(f_rd_data), .o_rd_empty(f_rd_empty),
        .o_rd_almost_empty(f_rd_aempty), .o_rd_count(f_rd_count), .o_rd_underflow(f_rd_unf)
    );

    task automatic wr_edge();
        @(posedge i_wr_clk);
        #1;
    endtask

    task automatic rd_edge();
        @(posedge i_rd_clk);
        #1;
    endtask

    task automatic write_word(input logic [7:0] d);
        i_write   = 1'b1;
        i_wr_data = d;
        exp_q.push_back(d);
        wr_edge();
        i_write   = 1'b0;
    endtask

    task automatic expect_reset_state(input string tag);
        checks++;
        if ({wr_full, wr_afull, wr_ovf, f_wr_full, f_wr_afull, f_wr_ovf} !== 6'b000000) begin
            errors++;
            $display("FAIL %s_wr_flags: got %b want 000000", tag,
                     {wr_full, wr_afull, wr_ovf, f_wr_full, f_wr_afull, f_wr_ovf});
        end
        checks++;
        if ({rd_empty, rd_aempty, rd_unf, f_rd_empty, f_rd_aempty, f_rd_unf} !== 6'b110110) begin
            errors++;
            $display("FAIL %s_rd_flags: got %b want 110110", tag,
                     {rd_empty, rd_aempty, rd_unf, f_rd_empty, f_rd_aempty, f_rd_unf});
        end
        checks++;
        if ({wr_count, rd_count, f_wr_count, f_rd_count} !== 16'h0000) begin
            errors++;
            $display("FAIL %s_counts: got %h want 0000", tag, {wr_count, rd_count, f_wr_count, f_rd_count});
        end
        checks++;
        if (f_rd_data !== 8'h00) begin
            errors++;
            $display("FAIL %s_fwft_data: got %h want 00", tag, f_rd_data);
        end
    endtask

    // Pops the direct instance until the scoreboard is empty; no writes may be in flight.
    task automatic do_drain(input string tag);
        int budget = 200;
        rd_edge();
        while (exp_q.size() != 0 && budget > 0) begin
            if (!rd_empty) begin
                checks++;
                if (rd_data !== exp_q[0]) begin
                    errors++;
                    $display("FAIL %s_data: got %h want %h", tag, rd_data, exp_q[0]);
                end
                checks++;
                if (rd_count !== CW'(exp_q.size()) || rd_aempty !== (exp_q.size() <= 2)) begin
                    errors++;
                    $display("FAIL %s_rd_count: got %0d/%b want %0d/%b", tag, rd_count, rd_aempty,
                             exp_q.size(), (exp_q.size() <= 2));
                end
                void'(exp_q.pop_front());
                i_read = 1'b1;
            end else begin
                i_read = 1'b0;
            end
            rd_edge();
            budget--;
        end
        i_read = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: got %0d words left want 0", tag, exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (rd_empty !== 1'b1 || rd_count !== '0) begin
            errors++;
            $display("FAIL %s_empty_after: got empty=%b count=%0d want 1/0", tag, rd_empty, rd_count);
        end
    endtask

    task automatic test_reset();
        expect_reset_state("reset");
    endtask

    task automatic test_latency();
        wr_edge();
        exp_f_q.push_back(8'h5C);
        write_word(8'h5C);
        for (int n = 1; n <= 4; n++) begin
            rd_edge();
            checks++;
            if (rd_empty !== (n < 3)) begin
                errors++;
                $display("FAIL latency_direct edge %0d: got empty=%b want %b", n, rd_empty, (n < 3));
            end
            checks++;
            if (f_rd_empty !== (n < 4)) begin
                errors++;
                $display("FAIL latency_fwft edge %0d: got empty=%b want %b", n, f_rd_empty, (n < 4));
            end
        end
        checks++;
        if (rd_data !== exp_q[0] || f_rd_data !== exp_f_q[0] || f_rd_count !== 4'd1) begin
            errors++;
            $display("FAIL latency_data: got %h/%h cnt %0d want %h/%h cnt 1", rd_data, f_rd_data,
                     f_rd_count, exp_q[0], exp_f_q[0]);
        end
        void'(exp_q.pop_front());
        void'(exp_f_q.pop_front());
        i_read   = 1'b1;
        i_read_f = 1'b1;
        rd_edge();
        i_read   = 1'b0;
        i_read_f = 1'b0;
        checks++;
        if (rd_empty !== 1'b1 || f_rd_empty !== 1'b1 || f_rd_data !== 8'h5C) begin
            errors++;
            $display("FAIL latency_pop: got empty=%b/%b fdata=%h want 1/1 5c", rd_empty, f_rd_empty, f_rd_data);
        end
        repeat (6) rd_edge();
    endtask

    task automatic test_fill_overflow();
        wr_edge();
        for (int i = 1; i <= DEPTH; i++) begin
            write_word(8'(i));
            checks++;
            if (wr_count !== CW'(i) || wr_afull !== (i >= 6) || wr_full !== (i == DEPTH)) begin
                errors++;
                $display("FAIL fill word %0d: got cnt=%0d af=%b f=%b want %0d/%b/%b", i, wr_count,
                         wr_afull, wr_full, i, (i >= 6), (i == DEPTH));
            end
        end
        i_write = 1'b1; i_wr_data = 8'hAA;
        wr_edge();
        i_write = 1'b0;
        checks++;
        if (wr_ovf !== 1'b1 || wr_count !== 4'd8) begin
            errors++;
            $display("FAIL overflow_set: got ovf=%b cnt=%0d want 1/8", wr_ovf, wr_count);
        end
        repeat (3) wr_edge();
        checks++;
        if (wr_ovf !== 1'b1) begin
            errors++;
            $display("FAIL overflow_hold: got %b want 1", wr_ovf);
        end
        i_write = 1'b1; i_wr_data = 8'hBB; i_wr_clr_err = 1'b1;
        wr_edge();
        i_write = 1'b0; i_wr_clr_err = 1'b0;
        checks++;
        if (wr_ovf !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set_beats_clear: got %b want 1", wr_ovf);
        end
        i_wr_clr_err = 1'b1;
        wr_edge();
        i_wr_clr_err = 1'b0;
        checks++;
        if (wr_ovf !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear: got %b want 0", wr_ovf);
        end
        repeat (3) rd_edge();
        do_drain("drain");
        repeat (4) wr_edge();
        checks++;
        if (wr_full !== 1'b0 || wr_count !== '0) begin
            errors++;
            $display("FAIL full_release: got full=%b cnt=%0d want 0/0", wr_full, wr_count);
        end
    endtask

    task automatic test_underflow();
        rd_edge();
        i_read = 1'b1;
        rd_edge();
        i_read = 1'b0;
        checks++;
        if (rd_unf !== 1'b1 || rd_empty !== 1'b1 || rd_count !== '0) begin
            errors++;
            $display("FAIL underflow_set: got unf=%b empty=%b cnt=%0d want 1/1/0", rd_unf, rd_empty, rd_count);
        end
        i_read = 1'b1; i_rd_clr_err = 1'b1;
        rd_edge();
        i_read = 1'b0; i_rd_clr_err = 1'b0;
        checks++;
        if (rd_unf !== 1'b1) begin
            errors++;
            $display("FAIL underflow_set_beats_clear: got %b want 1", rd_unf);
        end
        i_rd_clr_err = 1'b1;
        rd_edge();
        i_rd_clr_err = 1'b0;
        checks++;
        if (rd_unf !== 1'b0) begin
            errors++;
            $display("FAIL underflow_clear: got %b want 0", rd_unf);
        end
        wr_edge();
        write_word(8'h3C);
        repeat (4) rd_edge();
        do_drain("after_underflow");
    endtask

    task automatic test_random();
        fork
            begin : writer
                int sent = 0;
                int cyc  = 0;
                logic [7:0] d;
                wr_edge();
                while (sent < N_RND && cyc < 80000) begin
                    if (!wr_full && $urandom_range(3) != 0) begin
                        d         = 8'($urandom);
                        i_write   = 1'b1;
                        i_wr_data = d;
                        exp_q.push_back(d);
                        sent++;
                    end else begin
                        i_write = 1'b0;
                    end
                    wr_edge();
                    cyc++;
                    checks++;
                    if (!(wr_count <= 4'd8)) begin
                        errors++;
                        $display("FAIL random_wr_count: got %0d want <= 8", wr_count);
                    end
                end
                i_write = 1'b0;
            end
            begin : reader
                int got = 0;
                int cyc = 0;
                rd_edge();
                while (got < N_RND && cyc < 30000) begin
                    if (!rd_empty && $urandom_range(7) != 0) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL random_extra: got %h want no data", rd_data);
                        end else if (rd_data !== exp_q[0]) begin
                            errors++;
                            $display("FAIL random_data #%0d: got %h want %h", got, rd_data, exp_q[0]);
                        end
                        if (exp_q.size() != 0) void'(exp_q.pop_front());
                        got++;
                        i_read = 1'b1;
                    end else begin
                        i_read = 1'b0;
                    end
                    rd_edge();
                    cyc++;
                end
                i_read = 1'b0;
                checks++;
                if (got != N_RND) begin
                    errors++;
                    $display("FAIL random_timeout: got %0d words want %0d", got, N_RND);
                end
            end
        join
        checks++;
        if (rd_unf !== 1'b0 || wr_ovf !== 1'b0) begin
            errors++;
            $display("FAIL random_errors: got unf=%b ovf=%b want 0/0", rd_unf, wr_ovf);
        end
        exp_q.delete();
        repeat (4) rd_edge();
    endtask

    task automatic test_reset_mid();
        wr_edge();
        for (int i = 0; i < 5; i++) write_word(8'h40 + 8'(i));
        repeat (4) rd_edge();
        checks++;
        if (rd_count !== 4'd5) begin
            errors++;
            $display("FAIL mid_reset_held: got %0d want 5", rd_count);
        end
        #3.3;
        i_wr_rst_n = 1'b0;
        i_rd_rst_n = 1'b0;
        exp_q.delete();
        #1;
        expect_reset_state("in_reset");
        repeat (3) rd_edge();
        #2.2;
        i_wr_rst_n = 1'b1;
        i_rd_rst_n = 1'b1;
        wr_edge();
        rd_edge();
        expect_reset_state("post_reset");
        wr_edge();
        write_word(8'h77);
        repeat (4) rd_edge();
        do_drain("after_reset");
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got no finish want finish before 5 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #100.3;
        i_wr_rst_n = 1'b1;
        i_rd_rst_n = 1'b1;
        wr_edge();
        test_reset();
        test_latency();
        test_fill_overflow();
        test_underflow();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
